// File: rtl/conv_window_engine_if.sv
// rtl/conv_window_engine_if.sv - pixel/kernel/result bundle for conv_window_engine
// master drives pixels and weights; slave is the engine.
interface conv_window_engine_if #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int CNT_W = $clog2(OUT_W * OUT_H + 1);

  logic signed [DATA_W-1:0]   pxl_in;
  logic                       i_data_valid;
  logic [K*K*DATA_W-1:0]      i_kernel_data;
  logic signed [ACC_W-1:0]    pxl_out;
  logic                       o_data_valid;
  logic                       o_frame_done;
  logic [CNT_W-1:0]           count;

  modport master (
    output pxl_in, i_data_valid, i_kernel_data,
    input  pxl_out, o_data_valid, o_frame_done, count
  );

  modport slave (
    input  pxl_in, i_data_valid, i_kernel_data,
    output pxl_out, o_data_valid, o_frame_done, count
  );
endinterface

// File: rtl/conv_window_engine.sv
// rtl/conv_window_engine.sv - streaming KxK strided convolution over raster pixels
// Optional CONV_RELU_EN clamps negative results to zero before the output register.
module conv_window_engine #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_window_engine_if.slave  bus
);
  localparam int OUT_W    = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H    = (IMG_H - K) / STRIDE + 1;
  localparam int CNT_W    = $clog2(OUT_W * OUT_H + 1);
  localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LAST_ROW = (OUT_H - 1) * STRIDE + K - 1;
  localparam int LAST_COL = (OUT_W - 1) * STRIDE + K - 1;

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic                     accept;
  logic                     col_last;
  logic                     row_last;
  logic [31:0]              row32;
  logic [31:0]              col32;
  logic                     row_hit;
  logic                     col_hit;
  logic                     emit;
  logic                     last_win;

  logic signed [DATA_W-1:0] lb [K-1][IMG_W];
  logic signed [DATA_W-1:0] win [K][K];
  logic signed [DATA_W-1:0] new_col [K];
  logic [K*K*DATA_W-1:0]    kern;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    result;
  logic signed [ACC_W-1:0]    acc;

  logic                     fire1;
  logic                     done1;
  logic                     fire2;
  logic                     done2;
  logic                     valid_q;
  logic                     done_q;
  logic signed [ACC_W-1:0]  pxl_q;
  logic [CNT_W-1:0]         count_q;

  assign accept   = bus.i_data_valid;
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign row32    = 32'(row);
  assign col32    = 32'(col);

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // A window is complete only when its bottom-right pixel lands on a stride point.
  always_comb begin
    row_hit  = (row32 >= 32'(K - 1)) && (((row32 - 32'(K - 1)) % 32'(STRIDE)) == 32'd0);
    col_hit  = (col32 >= 32'(K - 1)) && (((col32 - 32'(K - 1)) % 32'(STRIDE)) == 32'd0);
    emit     = accept && row_hit && col_hit;
    last_win = emit && (row32 == 32'(LAST_ROW)) && (col32 == 32'(LAST_COL));
  end

  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = lb[r][col];
    end
    new_col[K-1] = bus.pxl_in;
  end

  // Line buffers and window are not reset; stale contents never reach a gated window.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < K - 2; r++) begin
        lb[r][col] <= lb[r+1][col];
      end
      lb[K-2][col] <= bus.pxl_in;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= new_col[r];
      end
      if (row == '0 && col == '0) begin
        kern <= bus.i_kernel_data;
      end
    end
  end

  always_comb begin
    sum  = '0;
    prod = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        prod = $signed(win[r][c]) * $signed(kern[(r*K+c)*DATA_W +: DATA_W]);
        sum  = sum + ACC_W'(prod);
      end
    end
  end

`ifdef CONV_RELU_EN
  assign result = sum[ACC_W-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  always_ff @(posedge clk) begin
    if (fire1) begin
      acc <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire1   <= 1'b0;
      done1   <= 1'b0;
      fire2   <= 1'b0;
      done2   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pxl_q   <= '0;
      count_q <= '0;
    end else begin
      fire1   <= emit;
      done1   <= last_win;
      fire2   <= fire1;
      done2   <= done1;
      valid_q <= fire2;
      done_q  <= done2;
      if (fire2) begin
        pxl_q <= acc;
      end
      count_q <= (done_q ? '0 : count_q) + CNT_W'(fire2);
    end
  end

  assign bus.pxl_out      = pxl_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_frame_done = done_q;
  assign bus.count        = count_q;
endmodule

// File: tb/tb_conv_window_engine.sv
// tb/tb_conv_window_engine.sv - directed checks of conv_window_engine on 5x5 frames
module tb_conv_window_engine;
  localparam int K      = 3;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int KW     = K * K * DATA_W;

`ifdef CONV_RELU_EN
  localparam longint NEG_EXP = 0;
`else
  localparam longint NEG_EXP = -9;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic signed [DATA_W-1:0] pxl;
  logic                     vld;
  logic                     sel;
  logic [KW-1:0]            kern;

  conv_window_engine_if #(.IMG_W(5), .IMG_H(5), .K(K), .STRIDE(1), .DATA_W(DATA_W), .ACC_W(ACC_W)) b1();
  conv_window_engine_if #(.IMG_W(5), .IMG_H(5), .K(K), .STRIDE(2), .DATA_W(DATA_W), .ACC_W(ACC_W)) b2();

  assign b1.pxl_in        = pxl;
  assign b1.i_data_valid  = vld && !sel;
  assign b1.i_kernel_data = kern;
  assign b2.pxl_in        = pxl;
  assign b2.i_data_valid  = vld && sel;
  assign b2.i_kernel_data = kern;

  conv_window_engine #(.IMG_W(5), .IMG_H(5), .K(K), .STRIDE(1), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_s1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  conv_window_engine #(.IMG_W(5), .IMG_H(5), .K(K), .STRIDE(2), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_s2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint q1_val[$];
  int     q1_cyc[$];
  int     q1_done[$];
  int     q1_cnt[$];
  int     q1_after[$];
  longint q2_val[$];
  int     q2_cyc[$];
  int     q2_done[$];
  logic   prev1 = 1'b0;

  always @(negedge clk) begin
    if (prev1) q1_after.push_back(int'(b1.count));
    prev1 = b1.o_frame_done;
    if (b1.o_data_valid) begin
      q1_val.push_back(longint'(b1.pxl_out));
      q1_cyc.push_back(cyc);
      q1_done.push_back(int'(b1.o_frame_done));
      q1_cnt.push_back(int'(b1.count));
    end
    if (b2.o_data_valid) begin
      q2_val.push_back(longint'(b2.pxl_out));
      q2_cyc.push_back(cyc);
      q2_done.push_back(int'(b2.o_frame_done));
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int acc_cyc[64];
  int trig1[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
  int trig2[4] = '{12, 14, 22, 24};
  longint exp2[4] = '{54, 72, 144, 162};

  function automatic logic [KW-1:0] kfill(input int w);
    logic [KW-1:0] v;
    for (int i = 0; i < K * K; i++) v[i*DATA_W +: DATA_W] = DATA_W'(w);
    return v;
  endfunction

  task automatic clear_q();
    q1_val.delete(); q1_cyc.delete(); q1_done.delete(); q1_cnt.delete(); q1_after.delete();
    q2_val.delete(); q2_cyc.delete(); q2_done.delete();
  endtask

  // Pixel p is presented #1 after an edge and taken on the next edge (cyc+1).
  task automatic drive(input int npix, input bit ramp, input bit stall,
                       input int kchg, input logic [KW-1:0] knew);
    int p = 0;
    int slot = 0;
    while (p < npix) begin
      @(posedge clk); #1;
      if (stall && (slot % 3 == 2)) begin
        vld = 1'b0;
      end else begin
        vld = 1'b1;
        pxl = ramp ? DATA_W'(p % 25) : DATA_W'(1);
        acc_cyc[p] = cyc + 1;
        if (p == kchg) kern = knew;
        p++;
      end
      slot++;
    end
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_frame1(input string tag, input int q_off, input int p_off, input longint expv);
    for (int k = 0; k < 9; k++) begin
      int i = q_off + k;
      if (i < q1_val.size()) begin
        check({tag, "_val"}, q1_val[i], expv);
        check({tag, "_lat"}, q1_cyc[i], acc_cyc[p_off + trig1[k]] + 2);
        check({tag, "_done"}, q1_done[i], (k == 8));
        check({tag, "_cnt"}, q1_cnt[i], k + 1);
      end
    end
  endtask

  initial begin
    vld = 1'b0; sel = 1'b0; pxl = '0; kern = kfill(1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid", b1.o_data_valid, 0);
    check("rst_done", b1.o_frame_done, 0);
    check("rst_count", b1.count, 0);
    check("rst_pxl", longint'(b1.pxl_out), 0);
    check("rst_count2", b2.count, 0);

    clear_q();
    drive(25, 1'b0, 1'b0, -1, '0);
    settle();
    check("t1_n", q1_val.size(), 9);
    check_frame1("t1", 0, 0, 9);
    check("t1_after_n", q1_after.size(), 1);
    if (q1_after.size() > 0) check("t1_cnt_clr", q1_after[0], 0);
    check("t1_hold", longint'(b1.pxl_out), 9);

    clear_q();
    drive(25, 1'b0, 1'b1, -1, '0);
    settle();
    check("t3_n", q1_val.size(), 9);
    check_frame1("t3", 0, 0, 9);

    clear_q();
    drive(12, 1'b0, 1'b0, -1, '0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("t4_rst_pxl", longint'(b1.pxl_out), 0);
    check("t4_rst_cnt", b1.count, 0);
    check("t4_aborted_n", q1_val.size(), 0);
    drive(25, 1'b0, 1'b0, -1, '0);
    settle();
    check("t4_n", q1_val.size(), 9);
    check_frame1("t4", 0, 0, 9);

    kern = kfill(-1);
    clear_q();
    drive(25, 1'b0, 1'b0, -1, '0);
    settle();
    check("t5_n", q1_val.size(), 9);
    check_frame1("t5", 0, 0, NEG_EXP);

    kern = kfill(1);
    clear_q();
    drive(50, 1'b0, 1'b0, 12, kfill(2));
    settle();
    check("t6_n", q1_val.size(), 18);
    check_frame1("t6a", 0, 0, 9);
    check_frame1("t6b", 9, 25, 18);
    check("t6_after_n", q1_after.size(), 2);
    for (int i = 0; i < q1_after.size(); i++) check("t6_cnt_clr", q1_after[i], 0);

    sel = 1'b1;
    kern = kfill(1);
    clear_q();
    drive(25, 1'b1, 1'b0, -1, '0);
    settle();
    check("t2_n", q2_val.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < q2_val.size()) begin
        check("t2_val", q2_val[k], exp2[k]);
        check("t2_lat", q2_cyc[k], acc_cyc[trig2[k]] + 2);
        check("t2_done", q2_done[k], (k == 3));
      end
    end
    check("t2_cnt_end", b2.count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
